// File: rtl/tp_dataflow_ctrl_if.sv
// tp_dataflow_ctrl_if: handshake bundle between the frame controller, its two child blocks and the top level
// master: controller side (drives child starts, top-level status, frame_cnt, stall_err)
// slave : environment side (drives ap_start, child ready/done/blk)
interface tp_dataflow_ctrl_if #(parameter int CNT_W = 16);
  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic ap_idle;
  logic p0_ap_start;
  logic p0_ap_ready;
  logic p0_ap_done;
  logic p0_blk;
  logic p1_ap_start;
  logic p1_ap_ready;
  logic p1_ap_done;
  logic p1_blk;
  logic [CNT_W-1:0] frame_cnt;
  logic stall_err;
  modport master (
    input  ap_start, p0_ap_ready, p0_ap_done, p0_blk, p1_ap_ready, p1_ap_done, p1_blk,
    output ap_ready, ap_done, ap_idle, p0_ap_start, p1_ap_start, frame_cnt, stall_err
  );
  modport slave (
    output ap_start, p0_ap_ready, p0_ap_done, p0_blk, p1_ap_ready, p1_ap_done, p1_blk,
    input  ap_ready, ap_done, ap_idle, p0_ap_start, p1_ap_start, frame_cnt, stall_err
  );
endinterface

// File: rtl/tp_dataflow_ctrl.sv
// tp_dataflow_ctrl: two-stage dataflow frame controller (producer p0, consumer p1) with optional stall watchdog
// Ports: ap_clk clock; ap_rst sync active-high reset; bus (tp_dataflow_ctrl_if.master) carries
//   ap_start/ap_ready/ap_done/ap_idle top-level handshake, pN_ap_start/pN_ap_ready/pN_ap_done/pN_blk
//   child handshakes, frame_cnt completed frames, stall_err sticky mutual-stall flag.
// Macro TP_DF_WATCHDOG_EN enables the mutual-stall watchdog; undefined ties stall_err to 0.
module tp_dataflow_ctrl #(
  parameter int STALL_LIMIT = 1024,
  parameter int CNT_W = 16
) (
  input logic ap_clk,
  input logic ap_rst,
  tp_dataflow_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic acc0, acc1, dn0, dn1;
  logic [CNT_W-1:0] cnt;
  logic run, set0, set1, fin0, fin1;
  assign run  = state == RUN;
  assign set0 = run & ~acc0 & bus.p0_ap_ready;
  assign set1 = run & ~acc1 & bus.p1_ap_ready;
  // done flags as they will be after this edge, so the same-cycle done counts
  assign fin0 = dn0 | (run & bus.p0_ap_done);
  assign fin1 = dn1 | (run & bus.p1_ap_done);
  assign bus.p0_ap_start = run & ~acc0;
  assign bus.p1_ap_start = run & ~acc1;
  // pulse only on the cycle the second acceptance lands; suppressed while reset is applied
  assign bus.ap_ready  = ~ap_rst & (set0 | set1) & (acc0 | set0) & (acc1 | set1);
  assign bus.ap_done   = state == DONE;
  assign bus.ap_idle   = state == IDLE;
  assign bus.frame_cnt = cnt;
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= IDLE;
      {acc0, acc1, dn0, dn1} <= '0;
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: state <= bus.ap_start ? RUN : IDLE;
        RUN: begin
          acc0 <= acc0 | set0;
          acc1 <= acc1 | set1;
          dn0 <= fin0;
          dn1 <= fin1;
          state <= (fin0 & fin1) ? DONE : RUN;
        end
        DONE: begin
          state <= IDLE;
          cnt <= cnt + 1'b1;
          {acc0, acc1, dn0, dn1} <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef TP_DF_WATCHDOG_EN
  localparam logic [15:0] LIMIT = 16'(STALL_LIMIT);
  logic [15:0] stall_cnt;
  logic err;
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      stall_cnt <= '0;
      err <= 1'b0;
    end else begin
      stall_cnt <= (run & bus.p0_blk & bus.p1_blk) ? ((stall_cnt == LIMIT) ? stall_cnt : stall_cnt + 16'd1) : '0;
      err <= err | (stall_cnt == LIMIT);
    end
  end
  assign bus.stall_err = err;
`else
  assign bus.stall_err = 1'b0;
`endif
endmodule

// File: tb/tb_tp_dataflow_ctrl.sv
// tb_tp_dataflow_ctrl: scoreboard bench for tp_dataflow_ctrl (frame timing, reset mid-run, counter wrap, watchdog)
module tb_tp_dataflow_ctrl;
  localparam int CW = 4;
  localparam int SL = 8;
`ifdef TP_DF_WATCHDOG_EN
  localparam logic WD = 1'b1;
`else
  localparam logic WD = 1'b0;
`endif
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  tp_dataflow_ctrl_if #(.CNT_W(CW)) bus ();
  tp_dataflow_ctrl #(.STALL_LIMIT(SL), .CNT_W(CW)) dut (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus.master));
  always #5 ap_clk = ~ap_clk;
  int n_chk = 0;
  int n_pass = 0;
  int cnt_m = 0;
  logic [CW-1:0] sbq[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask
  task automatic clr();
    bus.ap_start = 1'b0;
    bus.p0_ap_ready = 1'b0;
    bus.p0_ap_done = 1'b0;
    bus.p0_blk = 1'b0;
    bus.p1_ap_ready = 1'b0;
    bus.p1_ap_done = 1'b0;
    bus.p1_blk = 1'b0;
  endtask
  always @(negedge ap_clk) begin
    if (!ap_rst && bus.ap_done === 1'b1) begin
      if (sbq.size() == 0) chk("sb_unexpected_done", 32'(bus.ap_done), 32'd0);
      else chk("sb_frame_cnt", 32'(bus.frame_cnt), 32'(sbq.pop_front()));
    end
  end
  task automatic run_frame(input int r0, input int r1, input int d0, input int d1, input bit hold);
    int rm, dm;
    rm = (r0 > r1) ? r0 : r1;
    dm = (d0 > d1) ? d0 : d1;
    for (int c = 0; c <= dm + 2; c++) begin
      clr();
      bus.ap_start = (c == 0) || (hold && c == dm + 1);
      bus.p0_ap_ready = c == r0;
      bus.p1_ap_ready = c == r1;
      bus.p0_ap_done = (c == d0) || (c == dm + 2);
      bus.p1_ap_done = (c == d1) || (c == dm + 2);
      if (c == 0) sbq.push_back(CW'(cnt_m));
      #1;
      chk("ap_ready", 32'(bus.ap_ready), 32'(c == rm));
      chk("ap_done", 32'(bus.ap_done), 32'(c == dm + 1));
      chk("ap_idle", 32'(bus.ap_idle), 32'(c == 0 || c >= dm + 2));
      chk("p0_start", 32'(bus.p0_ap_start), 32'(c >= 1 && c <= r0));
      chk("p1_start", 32'(bus.p1_ap_start), 32'(c >= 1 && c <= r1));
      tick();
    end
    cnt_m = (cnt_m + 1) % (1 << CW);
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(cnt_m));
  endtask
  initial begin
    clr();
    ap_rst = 1'b1;
    repeat (3) tick();
    chk("rst_idle", 32'(bus.ap_idle), 32'd1);
    chk("rst_ready", 32'(bus.ap_ready), 32'd0);
    chk("rst_done", 32'(bus.ap_done), 32'd0);
    chk("rst_s0", 32'(bus.p0_ap_start), 32'd0);
    chk("rst_s1", 32'(bus.p1_ap_start), 32'd0);
    chk("rst_err", 32'(bus.stall_err), 32'd0);
    chk("rst_cnt", 32'(bus.frame_cnt), 32'd0);
    ap_rst = 1'b0;
    // reset in the middle of a frame, producer already accepted
    for (int c = 0; c <= 5; c++) begin
      clr();
      bus.ap_start = c == 0;
      bus.p0_ap_ready = c == 2;
      if (c == 5) begin
        #1;
        chk("mid_s0", 32'(bus.p0_ap_start), 32'd0);
        chk("mid_s1", 32'(bus.p1_ap_start), 32'd1);
        ap_rst = 1'b1;
        bus.p1_ap_ready = 1'b1;
        bus.p0_ap_done = 1'b1;
        bus.p1_ap_done = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus.ap_ready), 32'd0);
      end
      tick();
    end
    ap_rst = 1'b0;
    clr();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("after_rst_s1", 32'(bus.p1_ap_start), 32'd0);
      chk("after_rst_idle", 32'(bus.ap_idle), 32'd1);
      chk("after_rst_done", 32'(bus.ap_done), 32'd0);
      chk("after_rst_cnt", 32'(bus.frame_cnt), 32'd0);
      tick();
    end
    run_frame(2, 4, 10, 12, 1'b1);
    run_frame(2, 2, 5, 5, 1'b0);
    run_frame(3, 1, 3, 6, 1'b1);
    while (cnt_m != 15) begin
      int r0, r1;
      r0 = $urandom_range(1, 4);
      r1 = $urandom_range(1, 4);
      run_frame(r0, r1, $urandom_range(r0, r0 + 3), $urandom_range(r1, r1 + 3), 1'($urandom_range(0, 1)));
    end
    chk("wrap_15", 32'(bus.frame_cnt), 32'd15);
    run_frame(1, 2, 3, 4, 1'b0);
    chk("wrap_0", 32'(bus.frame_cnt), 32'd0);
    // watchdog: 7 stalled cycles then a gap, then a full STALL_LIMIT run
    clr();
    bus.ap_start = 1'b1;
    tick();
    clr();
    for (int i = 0; i < SL - 1; i++) begin
      bus.p0_blk = 1'b1;
      bus.p1_blk = 1'b1;
      #1;
      chk("wd_short", 32'(bus.stall_err), 32'd0);
      tick();
    end
    clr();
    #1;
    chk("wd_gap", 32'(bus.stall_err), 32'd0);
    tick();
    for (int i = 0; i < SL; i++) begin
      bus.p0_blk = 1'b1;
      bus.p1_blk = 1'b1;
      #1;
      chk("wd_long", 32'(bus.stall_err), 32'd0);
      tick();
    end
    clr();
    #1;
    chk("wd_lag", 32'(bus.stall_err), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("wd_set", 32'(bus.stall_err), 32'(WD));
      chk("wd_run", 32'(bus.p0_ap_start), 32'd1);
      tick();
    end
    bus.p0_ap_ready = 1'b1;
    bus.p1_ap_ready = 1'b1;
    bus.p0_ap_done = 1'b1;
    bus.p1_ap_done = 1'b1;
    sbq.push_back(CW'(cnt_m));
    #1;
    chk("wd_ready", 32'(bus.ap_ready), 32'd1);
    tick();
    clr();
    #1;
    chk("wd_done", 32'(bus.ap_done), 32'd1);
    cnt_m = (cnt_m + 1) % (1 << CW);
    tick();
    chk("wd_idle", 32'(bus.ap_idle), 32'd1);
    chk("wd_cnt", 32'(bus.frame_cnt), 32'(cnt_m));
    chk("wd_sticky", 32'(bus.stall_err), 32'(WD));
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    chk("final_err", 32'(bus.stall_err), 32'd0);
    chk("final_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("final_idle", 32'(bus.ap_idle), 32'd1);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
